day10_result_stream_writer: RTL
===============================

Name: day10_result_stream_writer

Overview:
Serialises one day-10 machine result onto an AXI-Stream master: a multi-beat little-endian min-press count header, followed by the button-press vector packed BITS_PER_BEAT bits per beat. Sits between the day-10 solver and the top-level output stream. It is the generalised successor of the single-beat-count, one-bit-per-beat writer. It adds:
- a configurable count width;
- configurable vector packing density;
- input snapshotting;
- a selectable tlast policy.

Parameters:
MAX_NUM_BUTTONS, 16, maximum button-vector length (>=1)
MAX_NUM_BUTTONS_W, MAX_NUM_BUTTONS<=1 ? 1 : $clog2(MAX_NUM_BUTTONS+1), width of num_buttons
COUNT_WIDTH, 16, width of min_presses (>=1)
AXI_DATA_WIDTH, 8, tdata width (>=1)
BITS_PER_BEAT, 1, vector bits carried per beat (1..AXI_DATA_WIDTH)
TLAST_PER_RECORD, 0, 1: tlast on every record's final beat; 0: only when last_write

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start  input  1  request to write one record; accepted only in IDLE
num_buttons  input  MAX_NUM_BUTTONS_W  vector length; values > MAX_NUM_BUTTONS clamp to MAX_NUM_BUTTONS
min_presses  input  COUNT_WIDTH  header value
buttons_to_press  input  MAX_NUM_BUTTONS  vector; bit i = button i
last_write  input  1  this record is the final record of the stream
busy  output  1  record in progress (HDR or VEC state)
done  output  1  one-cycle pulse after the record's final handshake
m_tdata  output  AXI_DATA_WIDTH  stream data
m_tvalid  output  1  stream valid
m_tready  input  1  stream ready
m_tlast  output  1  stream last

Behaviour:
Interface: reset rst_n, synchronous, active-low; clock clk. All outputs are registered.

Reset:
- m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0; state=IDLE.

Derived constants:
- HDR_BEATS = ceil(COUNT_WIDTH/AXI_DATA_WIDTH).
- VEC_BEATS = ceil(n/BITS_PER_BEAT), computed from the clamped snapshot n.

States:
- IDLE -> HDR on start. Snapshot num_buttons (clamped), min_presses, buttons_to_press and last_write into registers. Later input changes have no effect on the record.
- HDR: beat k (0..HDR_BEATS-1) carries min_presses[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH]. Bits above COUNT_WIDTH are zero. After the last header beat: go to VEC if n>0, else DONE.
- VEC: beat j carries buttons[j*BITS_PER_BEAT +: BITS_PER_BEAT] in tdata[BITS_PER_BEAT-1:0]. Vector bits at index >= n are masked to 0; tdata bits above BITS_PER_BEAT are 0. After the last beat go to DONE.
- DONE: done=1 for exactly this cycle, busy=0, m_tvalid=0; next state IDLE.

Handshake:
- A beat completes on m_tvalid && m_tready.
- While m_tvalid && !m_tready, m_tdata/m_tlast/m_tvalid hold stable.
- m_tvalid never drops mid-record without a handshake, except on reset.

tlast:
- Asserted only on the record's final beat, and only if TLAST_PER_RECORD=1 or the snapshotted last_write=1.
- When n=0 the final beat is the last header beat.

Timing:
- start sampled at edge 0 -> busy=1 and m_tvalid=1 with beat 0 after edge 0.
- With m_tready held high, beats are back-to-back, one per cycle.
- done is high in the cycle after the final handshake.
- The next start is accepted no earlier than the cycle after done.

Boundary conditions:
- start while busy or in DONE is ignored (not queued).
- Reset mid-record: after the reset edge m_tvalid=0 and the state is IDLE. No done pulse; the partial record is abandoned.
- Beat counters use a width sufficient for max(HDR_BEATS, ceil(MAX_NUM_BUTTONS/BITS_PER_BEAT)). No wrap-around within a record.

Test Plan:
1. Defaults, min_presses=0x0203, n=3, buttons=0b101, last_write=0, tready=1 -> beats 0x03,0x02,0x01,0x00,0x01 on 5 consecutive cycles; tlast never set; done one cycle after 5th beat; busy high exactly 5 cycles.
2. Same with last_write=1 -> identical data; tlast=1 only on 5th beat (0x01).
3. BITS_PER_BEAT=4, n=6, buttons=0xFFFF, min=0x0001 -> 0x01,0x00,0x0F,0x03; upper tdata bits 0.
4. Case 1 with tready toggling 0,1,0,1,... -> tdata/tvalid held during stalls; exactly 5 handshakes with identical data; inputs changed after start do not alter beats.
5. n=0, last_write=1, min=0xABCD -> exactly 2 beats 0xCD,0xAB; tlast on 0xAB; done follows.
6. rst_n low during VEC beat 1 -> m_tvalid=0 and busy=0 after the edge, no done. A new start then produces a complete correct record. A start pulsed while busy produces no extra record.

Source files
------------

// File: rtl/day10_result_stream_writer.sv
// Day-10 result writer: streams one record as a little-endian min-press count header
// followed by the button-press vector, BITS_PER_BEAT vector bits per AXI-Stream beat.
module day10_result_stream_writer #(
  parameter int MAX_NUM_BUTTONS   = 16,
  parameter int MAX_NUM_BUTTONS_W = (MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1),
  parameter int COUNT_WIDTH       = 16,
  parameter int AXI_DATA_WIDTH    = 8,
  parameter int BITS_PER_BEAT     = 1,
  parameter int TLAST_PER_RECORD  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [MAX_NUM_BUTTONS_W-1:0] num_buttons,
  input  logic [COUNT_WIDTH-1:0]       min_presses,
  input  logic [MAX_NUM_BUTTONS-1:0]   buttons_to_press,
  input  logic                         last_write,
  output logic                         busy,
  output logic                         done,
  output logic [AXI_DATA_WIDTH-1:0]    m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         m_tlast
);

  localparam int HDR_BEATS     = (COUNT_WIDTH + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH;
  localparam int HDR_PAD       = HDR_BEATS * AXI_DATA_WIDTH;
  localparam int VEC_MAX_BEATS = (MAX_NUM_BUTTONS + BITS_PER_BEAT - 1) / BITS_PER_BEAT;
  localparam int VEC_PAD       = VEC_MAX_BEATS * BITS_PER_BEAT;
  localparam int MAX_BEATS     = (HDR_BEATS > VEC_MAX_BEATS) ? HDR_BEATS : VEC_MAX_BEATS;
  localparam int CNT_W         = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {StIdle, StHdr, StVec, StDone} state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             beat_q, beat_d;
  logic [MAX_NUM_BUTTONS_W-1:0] n_q, n_d;
  logic [COUNT_WIDTH-1:0]       count_q, count_d;
  logic [MAX_NUM_BUTTONS-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]             vec_last_q, vec_last_d;
  logic                         last_q, last_d;

  logic [AXI_DATA_WIDTH-1:0]    tdata_d;
  logic                         tvalid_d, tlast_d, busy_d, done_d;

  logic [MAX_NUM_BUTTONS_W-1:0] n_clamp;
  logic [MAX_NUM_BUTTONS-1:0]   vec_masked;
  logic [CNT_W-1:0]             vec_last_in;
  logic                         hs;

  assign hs = m_tvalid && m_tready;

  // Clamp the requested length and mask off vector bits beyond it before snapshotting.
  always_comb begin
    n_clamp = num_buttons;
    if (num_buttons > MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS)) begin
      n_clamp = MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS);
    end
    vec_masked = '0;
    for (int i = 0; i < MAX_NUM_BUTTONS; i++) begin
      vec_masked[i] = buttons_to_press[i] & (32'(i) < 32'(n_clamp));
    end
    // Index of the final vector beat; unused when the vector is empty.
    vec_last_in = CNT_W'((32'(n_clamp) + 32'(BITS_PER_BEAT) - 32'd1) / 32'(BITS_PER_BEAT)
                         - 32'd1);
  end

  // Next-state: snapshot on start, advance the beat index on each handshake.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    n_d        = n_q;
    count_d    = count_q;
    vec_d      = vec_q;
    vec_last_d = vec_last_q;
    last_d     = last_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StHdr;
          beat_d     = '0;
          n_d        = n_clamp;
          count_d    = min_presses;
          vec_d      = vec_masked;
          vec_last_d = vec_last_in;
          last_d     = last_write;
        end
      end
      StHdr: begin
        if (hs) begin
          if (beat_q == CNT_W'(HDR_BEATS - 1)) begin
            beat_d  = '0;
            state_d = (n_q != '0) ? StVec : StDone;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      StVec: begin
        if (hs) begin
          if (beat_q == vec_last_q) begin
            state_d = StDone;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next-values derived from the next state so every output is a plain register;
  // during a stall nothing changes, so the beat holds stable.
  always_comb begin
    logic [HDR_PAD-1:0] hdr_pad;
    logic [VEC_PAD-1:0] vec_pad;
    hdr_pad                  = '0;
    hdr_pad[COUNT_WIDTH-1:0] = count_d;
    vec_pad                  = '0;
    vec_pad[MAX_NUM_BUTTONS-1:0] = vec_d;
    tdata_d  = '0;
    tlast_d  = 1'b0;
    tvalid_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_d)
      StHdr: begin
        tvalid_d = 1'b1;
        busy_d   = 1'b1;
        for (int k = 0; k < HDR_BEATS; k++) begin
          if (beat_d == CNT_W'(k)) tdata_d = hdr_pad[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        end
        tlast_d = (beat_d == CNT_W'(HDR_BEATS - 1)) && (n_d == '0) &&
                  ((TLAST_PER_RECORD != 0) || last_d);
      end
      StVec: begin
        tvalid_d = 1'b1;
        busy_d   = 1'b1;
        for (int j = 0; j < VEC_MAX_BEATS; j++) begin
          if (beat_d == CNT_W'(j)) begin
            tdata_d[BITS_PER_BEAT-1:0] = vec_pad[j*BITS_PER_BEAT +: BITS_PER_BEAT];
          end
        end
        tlast_d = (beat_d == vec_last_d) && ((TLAST_PER_RECORD != 0) || last_d);
      end
      StDone: begin
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, snapshot and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      n_q        <= '0;
      count_q    <= '0;
      vec_q      <= '0;
      vec_last_q <= '0;
      last_q     <= 1'b0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      n_q        <= n_d;
      count_q    <= count_d;
      vec_q      <= vec_d;
      vec_last_q <= vec_last_d;
      last_q     <= last_d;
      m_tdata    <= tdata_d;
      m_tvalid   <= tvalid_d;
      m_tlast    <= tlast_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule
